// File: rtl/el2_lsu_halt_ctl.sv
// el2_lsu_halt_ctl
//
// LSU-side responder for the TLU halt handshake. Once TLU requests a halt,
// new LSU issue is blocked. Halt is acknowledged only after the LSU has been
// completely empty for IDLE_HYST consecutive cycles. Force halt skips that wait.
//
// Optional feature: define EL2_LSU_HALT_TIMEOUT_EN to add a sticky drain
// timeout flag. It sets after DRAIN_TIMEOUT cycles spent in DRAIN/QUIET.
// When the macro is undefined, lsu_halt_timeout is tied to 0.
//
// Ports:
//   clk, rst_l                  clock, async active-low reset
//   dec_tlu_halt_req            level halt request from TLU
//   dec_tlu_force_halt          level immediate halt, bypasses the drain
//   lsu_p_valid .. lsu_busreq_r pipe / DMA / bus activity (1 = busy)
//   lsu_stbuf_empty_any         store buffer empty
//   lsu_bus_buffer_empty_any    bus buffer empty
//   lsu_halt_block_d            block new LSU issue from decode
//   lsu_idle_any                all_empty, delayed one cycle
//   lsu_halt_ack                halt acknowledge to TLU
//   lsu_halt_state              FSM state (0 RUN, 1 DRAIN, 2 QUIET, 3 HALTED)
//   lsu_halt_timeout            sticky drain timeout flag
module el2_lsu_halt_ctl #(
    parameter int unsigned IDLE_HYST     = 4,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       dec_tlu_halt_req,
    input  logic       dec_tlu_force_halt,
    input  logic       lsu_p_valid,
    input  logic       lsu_pkt_d_valid,
    input  logic       lsu_pkt_m_valid,
    input  logic       lsu_pkt_r_valid,
    input  logic       dma_dccm_req,
    input  logic       lsu_busreq_r,
    input  logic       lsu_stbuf_empty_any,
    input  logic       lsu_bus_buffer_empty_any,
    output logic       lsu_halt_block_d,
    output logic       lsu_idle_any,
    output logic       lsu_halt_ack,
    output logic [1:0] lsu_halt_state,
    output logic       lsu_halt_timeout
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StQuiet  = 2'd2,
        StHalted = 2'd3
    } halt_state_e;

    localparam logic [3:0] QuietLast = 4'(IDLE_HYST - 1);

    // Catch illegal parameter values at elaboration time.
    if (IDLE_HYST < 1 || IDLE_HYST > 15) begin : g_bad_idle_hyst
        $error("IDLE_HYST must be in 1..15");
    end
    if (DRAIN_TIMEOUT < 2 || DRAIN_TIMEOUT > 65535) begin : g_bad_drain_timeout
        $error("DRAIN_TIMEOUT must be in 2..65535");
    end

    halt_state_e state_q, state_d;
    logic [3:0]  quiet_cnt_q, quiet_cnt_d;
    logic        idle_q;
    logic        block_q, block_d;
    logic        ack_q, ack_d;
    logic        all_empty;

    assign all_empty = ~(lsu_p_valid | lsu_pkt_d_valid | lsu_pkt_m_valid | lsu_pkt_r_valid |
                         dma_dccm_req | lsu_busreq_r) &
                       lsu_stbuf_empty_any & lsu_bus_buffer_empty_any;

    // Next-state logic. Priority: force halt, then halt_req deassert, then
    // activity, then hysteresis expiry.
    always_comb begin
        state_d     = state_q;
        quiet_cnt_d = '0;
        if (dec_tlu_force_halt) begin
            state_d = StHalted;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (dec_tlu_halt_req) state_d = StDrain;
                end
                StDrain: begin
                    if (!dec_tlu_halt_req) state_d = StRun;
                    else if (all_empty)    state_d = StQuiet;
                end
                StQuiet: begin
                    if (!dec_tlu_halt_req) begin
                        state_d = StRun;
                    end else if (!all_empty) begin
                        state_d = StDrain;
                    end else if (quiet_cnt_q == QuietLast) begin
                        state_d = StHalted;
                    end else begin
                        quiet_cnt_d = (quiet_cnt_q == 4'hf) ? quiet_cnt_q : quiet_cnt_q + 4'd1;
                    end
                end
                StHalted: begin
                    // Only DMA wakes a halted LSU. Pipe activity is not expected here.
                    if (!dec_tlu_halt_req) state_d = StRun;
                    else if (dma_dccm_req) state_d = StDrain;
                end
                default: state_d = StRun;
            endcase
        end
        block_d = (state_d != StRun);
        ack_d   = (state_d == StHalted);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= StRun;
            quiet_cnt_q <= '0;
            idle_q      <= 1'b0;
            block_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quiet_cnt_q <= quiet_cnt_d;
            idle_q      <= all_empty;
            block_q     <= block_d;
            ack_q       <= ack_d;
        end
    end

    assign lsu_halt_block_d = block_q;
    assign lsu_halt_ack     = ack_q;
    assign lsu_idle_any     = idle_q;
    assign lsu_halt_state   = state_q;

`ifdef EL2_LSU_HALT_TIMEOUT_EN
    localparam logic [15:0] DrainLast = 16'(DRAIN_TIMEOUT - 1);

    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        timeout_q, timeout_d;
    logic        draining;

    always_comb begin
        draining    = (state_q == StDrain) || (state_q == StQuiet);
        drain_cnt_d = '0;
        if (draining) begin
            drain_cnt_d = (drain_cnt_q == 16'hffff) ? drain_cnt_q : drain_cnt_q + 16'd1;
        end
        timeout_d = timeout_q | (draining && (drain_cnt_q == DrainLast));
        // The flag is dropped together with the return to RUN.
        if (state_d == StRun) timeout_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign lsu_halt_timeout = timeout_q;
`else
    assign lsu_halt_timeout = 1'b0;
`endif

endmodule

// File: doc/el2_lsu_halt_ctl.md
Name: el2_lsu_halt_ctl

Overview:
- LSU-side responder for the TLU halt/power-management handshake.
- Consumes the same pipe-valid, DMA, store-buffer and bus-buffer activity indications that drive LSU clock-gating enables.
- Asserts a halt acknowledge only after the LSU has drained and stayed quiet for a programmable hysteresis window, so TLU can safely gate the LSU clocks.
- Sits beside the LSU clock-enable logic, between dec/TLU and the LSU pipe.

Parameters:
- IDLE_HYST, 4: consecutive all-empty cycles required in QUIET before acknowledging halt; legal 1..15.
- DRAIN_TIMEOUT, 1024: cycles in DRAIN+QUIET before the timeout flag sets (optional feature only); legal 2..65535.

Ports:
- clk  in  1  free-running LSU clock (active_clk domain)
- rst_l  in  1  reset; asynchronous assert, active low
- dec_tlu_halt_req  in  1  level; TLU requests LSU quiesce
- dec_tlu_force_halt  in  1  level; immediate halt, bypasses drain
- lsu_p_valid  in  1  LSU packet valid in decode
- lsu_pkt_d_valid  in  1  LSU packet valid in d
- lsu_pkt_m_valid  in  1  LSU packet valid in m
- lsu_pkt_r_valid  in  1  LSU packet valid in r
- dma_dccm_req  in  1  DMA access to DCCM active
- lsu_busreq_r  in  1  bus request in r
- lsu_stbuf_empty_any  in  1  store buffer empty
- lsu_bus_buffer_empty_any  in  1  external bus buffer empty
- lsu_halt_block_d  out  1  block new LSU issue from decode
- lsu_idle_any  out  1  registered all_empty
- lsu_halt_ack  out  1  halt acknowledge to TLU
- lsu_halt_state  out  2  FSM state, for debug
- lsu_halt_timeout  out  1  drain timeout, sticky

Behaviour:
- Reset: port names are clk and rst_l; reset is asynchronous and active-low. All flops clear. State=RUN, quiet_cnt=0, all outputs 0.
- Quiet condition, combinational: all_empty = ~(lsu_p_valid|lsu_pkt_d_valid|lsu_pkt_m_valid|lsu_pkt_r_valid|dma_dccm_req|lsu_busreq_r) & lsu_stbuf_empty_any & lsu_bus_buffer_empty_any.
- lsu_idle_any is all_empty registered: 1-cycle latency, updated in every state.
- State encoding: RUN=0, DRAIN=1, QUIET=2, HALTED=3. All outputs are registered or decoded directly from state.
- RUN:
  - block_d=0, ack=0.
  - halt_req=1 -> DRAIN.
- DRAIN:
  - block_d=1.
  - halt_req=0 -> RUN (takes priority).
  - Else all_empty=1 -> QUIET with quiet_cnt=0.
- QUIET:
  - block_d=1.
  - halt_req=0 -> RUN.
  - Else all_empty=0 -> DRAIN with quiet_cnt cleared.
  - Else if quiet_cnt==IDLE_HYST-1 -> HALTED.
  - Else quiet_cnt+1.
  - quiet_cnt is 4 bits and saturates; it never wraps.
- HALTED:
  - block_d=1, ack=1.
  - halt_req=0 and force_halt=0 -> RUN; ack and block_d drop together.
  - dma_dccm_req=1 while halt_req=1 -> DRAIN; ack drops the next cycle. DMA is serviced, then re-quiesce.
- Force halt:
  - dec_tlu_force_halt=1 in any state -> HALTED on the next edge, regardless of activity.
  - Force halt overrides halt_req=0 and dma_dccm_req.
  - HALTED is held while force_halt=1.
- Minimum ack latency from halt_req rise with the LSU already empty: 1 (DRAIN) + 1 (QUIET entry) + IDLE_HYST cycles.
- Simultaneous events: force_halt beats halt_req deassert, which beats activity, which beats counter expiry.
- Reset mid-operation: rst_l low in any state returns the FSM to RUN immediately and drops ack with no glitch-free guarantee required. TLU re-requests after reset.

Optional Feature:
- Macro: EL2_LSU_HALT_TIMEOUT_EN.
- When defined:
  - A 16-bit drain_cnt clears on RUN and HALTED, and increments each cycle in DRAIN or QUIET, saturating.
  - When drain_cnt==DRAIN_TIMEOUT-1, lsu_halt_timeout sets on the next edge.
  - lsu_halt_timeout stays set until state returns to RUN or reset.
  - The timeout does not force HALTED; TLU decides.
- When undefined: no counter is instantiated and lsu_halt_timeout is tied 0.

Test Plan:
- Empty LSU, IDLE_HYST=4, raise halt_req at cycle 0 -> block_d=1 at cycle 1, ack=1 at cycle 6, state=3.
- halt_req with lsu_stbuf_empty_any=0 for 10 cycles -> state stays DRAIN, ack=0; stbuf empties at cycle 10 -> ack at cycle 10+1+4.
- In QUIET with quiet_cnt=2, pulse lsu_pkt_r_valid one cycle -> state DRAIN, quiet_cnt=0, ack delayed by a full IDLE_HYST window.
- In HALTED, assert dma_dccm_req for 3 cycles -> ack drops the next cycle, state DRAIN; re-ack 1+1+IDLE_HYST cycles after DMA ends.
- In DRAIN with activity, assert dec_tlu_force_halt -> HALTED and ack=1 next edge; deassert halt_req while force_halt=1 -> stays HALTED.
- With EL2_LSU_HALT_TIMEOUT_EN, DRAIN_TIMEOUT=8, bus buffer never empties -> lsu_halt_timeout=1 eight cycles after DRAIN entry; drop halt_req -> RUN, flag clears. Without the macro the flag stays 0.
